// File: rtl/ws2812b_serializer_pkg.sv
// Shared definitions for the WS2812B output path: default 100 MHz timing and FSM encodings.
// Also imported by the pattern stage and the bench, so keep encodings stable.
package ws2812b_serializer_pkg;

    localparam int DEF_N_LEDS = 4;
    localparam int DEF_T0H    = 40;    // 0.40 us high for a '0'
    localparam int DEF_T1H    = 80;    // 0.80 us high for a '1'
    localparam int DEF_TBIT   = 125;   // 1.25 us per bit
    localparam int DEF_TRST   = 6000;  // 60 us latch, above the 50 us minimum

    // Line phase of the bit encoder.
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_HIGH = 2'd1,
        PH_LOW  = 2'd2
    } bitPhase_t;

    // Frame-level state of the serializer.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_LATCH = 2'd3
    } serState_t;

endpackage

// File: rtl/ws2812b_serializer_if.sv
// Frame handshake between the pattern stage (master) and the serializer (slave).
interface ws2812b_serializer_if #(
    parameter int FRAME_W = 24 * ws2812b_serializer_pkg::DEF_N_LEDS
);
    logic [FRAME_W-1:0] frameIn;
    logic               start;
    logic               dout;
    logic               busy;
    logic               done;

    modport master (output frameIn, start, input  dout, busy, done);
    modport slave  (input  frameIn, start, output dout, busy, done);
endinterface

// File: rtl/ws2812b_bit_encoder.sv
// Emits one pulse-width-coded WS2812B bit per go: T0H/T1H high, then low up to TBIT.
// A go seen on the final cycle of a bit starts the next bit with no gap.
module ws2812b_bit_encoder
    import ws2812b_serializer_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic bitVal,
    output logic dout,
    output logic bitDone
);
    localparam int CW = $clog2(TBIT);

    bitPhase_t     phase;
    logic [CW-1:0] cyc;
    logic          bitReg;
    logic [CW-1:0] hiLast;

    assign hiLast  = bitReg ? CW'(T1H - 1) : CW'(T0H - 1);
    assign bitDone = (phase == PH_LOW) && (cyc == CW'(TBIT - 1));

    // NOTE: every register here uses <= so all reads within one edge see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase  <= PH_IDLE;
            cyc    <= '0;
            bitReg <= 1'b0;
            dout   <= 1'b0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (go) begin
                        bitReg <= bitVal;
                        cyc    <= '0;
                        dout   <= 1'b1;
                        phase  <= PH_HIGH;
                    end
                end
                PH_HIGH: begin
                    cyc <= cyc + CW'(1);
                    if (cyc == hiLast) begin
                        dout  <= 1'b0;
                        phase <= PH_LOW;
                    end
                end
                PH_LOW: begin
                    if (bitDone) begin
                        cyc <= '0;
                        if (go) begin
                            bitReg <= bitVal;
                            dout   <= 1'b1;
                            phase  <= PH_HIGH;
                        end else begin
                            phase <= PH_IDLE;
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                default: begin
                    dout  <= 1'b0;
                    phase <= PH_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/ws2812b_serializer.sv
// Latches a GRB frame on start and streams it MSB first to a WS2812B strip, then holds
// the line low for TRST cycles. Reset lands in the latch so the strip resyncs afterwards.
module ws2812b_serializer
    import ws2812b_serializer_pkg::*;
#(
    parameter int N_LEDS = DEF_N_LEDS,
    parameter int T0H    = DEF_T0H,
    parameter int T1H    = DEF_T1H,
    parameter int TBIT   = DEF_TBIT,
    parameter int TRST   = DEF_TRST
) (
    input  logic                  clk,
    input  logic                  reset,
    ws2812b_serializer_if.slave   bus
);
    localparam int FRAME_W = 24 * N_LEDS;
    localparam int CYC_W   = $clog2(TBIT > TRST ? TBIT : TRST);
    localparam int BIT_W   = $clog2(FRAME_W);

    serState_t          state;
    logic [FRAME_W-2:0] shreg;      // bits still to send after the one in the encoder
    logic [BIT_W-1:0]   bitCnt;
    logic [CYC_W-1:0]   latchCyc;
    logic               busyQ;
    logic               doneQ;
    logic               go;
    logic               bitVal;
    logic               bitDone;
    logic               lineOut;
    logic               lastBit;

    assign lastBit  = (bitCnt == BIT_W'(FRAME_W - 1));
    assign bus.dout = lineOut;
    assign bus.busy = busyQ;
    assign bus.done = doneQ;

    always_comb begin
        go     = 1'b0;
        bitVal = 1'b0;
        case (state)
            S_IDLE: begin
                go     = bus.start;
                bitVal = bus.frameIn[FRAME_W-1];
            end
            S_SEND: begin
                go     = bitDone && !lastBit;
                bitVal = shreg[FRAME_W-2];
            end
            default: ;
        endcase
    end

    ws2812b_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) encoder (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .bitVal  (bitVal),
        .dout    (lineOut),
        .bitDone (bitDone)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the shift register is a plain flop array, so it is cleared like any other state.
            state    <= S_LATCH;
            shreg    <= '0;
            bitCnt   <= '0;
            latchCyc <= '0;
            busyQ    <= 1'b1;
            doneQ    <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        shreg  <= bus.frameIn[FRAME_W-2:0];
                        bitCnt <= '0;
                        busyQ  <= 1'b1;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bitDone) begin
                        if (lastBit) begin
                            latchCyc <= '0;
                            state    <= S_LATCH;
                        end else begin
                            bitCnt <= bitCnt + BIT_W'(1);
                            shreg  <= shreg << 1;
                        end
                    end
                end
                S_LATCH: begin
                    latchCyc <= latchCyc + CYC_W'(1);
                    // Registered one cycle early so done lines up with the final latch cycle.
                    if (latchCyc == CYC_W'(TRST - 2)) doneQ <= 1'b1;
                    if (latchCyc == CYC_W'(TRST - 1)) begin
                        latchCyc <= '0;
                        busyQ    <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    busyQ <= 1'b1;
                    state <= S_LATCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812b_serializer.sv
// Bench: small-timing instance for waveform/corner checks, default instance for real timing.
module tb_ws2812b_serializer;

    localparam int S_T0H  = 2;
    localparam int S_T1H  = 4;
    localparam int S_TBIT = 6;
    localparam int S_TRST = 10;
    localparam int S_FW   = 24;
    localparam int D_FW   = 96;

    logic clk;
    logic reset;
    int   nTests = 0;
    int   nFail  = 0;

    ws2812b_serializer_if #(.FRAME_W(S_FW)) busS();
    ws2812b_serializer_if #(.FRAME_W(D_FW)) busD();

    ws2812b_serializer #(
        .N_LEDS(1), .T0H(S_T0H), .T1H(S_T1H), .TBIT(S_TBIT), .TRST(S_TRST)
    ) dutS (
        .clk   (clk),
        .reset (reset),
        .bus   (busS)
    );

    ws2812b_serializer dutD (
        .clk   (clk),
        .reset (reset),
        .bus   (busD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Post-reset latch on the small instance: starts at the negedge where reset drops.
    task automatic watchLatch(input string name);
        int busyC = 0;
        int doneC = 0;
        int highC = 0;
        for (int c = 0; c < 40; c++) begin
            if (busS.busy) busyC++;
            if (busS.done) doneC++;
            if (busS.dout) highC++;
            if (!busS.busy) break;
            @(negedge clk);
        end
        check({name, " busy cycles"}, busyC, S_TRST);
        check({name, " done pulses"}, doneC, 1);
        check({name, " dout high cycles"}, highC, 0);
    endtask

    // One frame on the small instance, compared cycle by cycle against a waveform built
    // directly from the bit-timing rules. Called and returns at a negedge.
    task automatic runSmall(input string name, input logic [23:0] frame, input bit disturb,
                            output int highC, output int busyC);
        logic expD[$];
        logic expDn[$];
        int   errs;
        int   firstBad;
        int   doneC;
        int   h;
        logic eD, eB, eDn;
        errs = 0; firstBad = -1; doneC = 0; highC = 0; busyC = 0;
        for (int i = S_FW - 1; i >= 0; i--) begin
            h = frame[i] ? S_T1H : S_T0H;
            for (int c = 0; c < S_TBIT; c++) begin
                expD.push_back(c < h);
                expDn.push_back(1'b0);
            end
        end
        for (int c = 0; c < S_TRST; c++) begin
            expD.push_back(1'b0);
            expDn.push_back(c == S_TRST - 1);
        end
        busS.frameIn = frame;
        busS.start   = 1'b1;
        @(negedge clk);
        busS.start = 1'b0;
        for (int c = 0; c < expD.size() + 3; c++) begin
            eD  = (c < expD.size()) ? expD[c] : 1'b0;
            eDn = (c < expD.size()) ? expDn[c] : 1'b0;
            eB  = (c < expD.size());
            if (busS.dout !== eD || busS.busy !== eB || busS.done !== eDn) begin
                errs++;
                if (firstBad < 0) firstBad = c;
            end
            if (busS.dout) highC++;
            if (busS.busy) busyC++;
            if (busS.done) doneC++;
            if (disturb && c == 30) busS.frameIn = ~frame;
            if (disturb && c == 50) busS.start = 1'b1;
            if (disturb && c == 51) busS.start = 1'b0;
            @(negedge clk);
        end
        if (errs != 0) $display("  %s: first waveform difference at cycle %0d", name, firstBad);
        check({name, " waveform errors"}, errs, 0);
        check({name, " done pulses"}, doneC, 1);
    endtask

    typedef struct {
        logic [23:0] frame;
        int          expHigh;
        int          expBusy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          highC, busyC;
        logic [23:0] rf;
        logic [95:0] fD;
        logic [95:0] dec;
        int          lens[$];
        int          rises[$];
        int          t, hiLen, bad;
        logic        prevD;

        vecs[0] = '{24'h800001, 52, 154};
        vecs[1] = '{24'h000000, 48, 154};
        vecs[2] = '{24'hFFFFFF, 96, 154};
        vecs[3] = '{24'hA5A5A5, 72, 154};
        vecs[4] = '{24'h0F0F0F, 72, 154};
        vecs[5] = '{24'h800000, 50, 154};

        reset = 1'b1;
        busS.start = 1'b0; busS.frameIn = '0;
        busD.start = 1'b0; busD.frameIn = '0;
        repeat (2) @(negedge clk);
        check("reset dout", busS.dout, 0);
        check("reset busy", busS.busy, 1);
        check("reset done", busS.done, 0);
        reset = 1'b0;
        watchLatch("initial latch");

        foreach (vecs[i]) begin
            runSmall($sformatf("vec%0d", i), vecs[i].frame, 1'b0, highC, busyC);
            check($sformatf("vec%0d high cycles", i), highC, vecs[i].expHigh);
            check($sformatf("vec%0d busy cycles", i), busyC, vecs[i].expBusy);
        end

        for (int i = 0; i < 4; i++) begin
            rf = 24'($urandom);
            runSmall($sformatf("rand%0d %06h", i, rf), rf, 1'b0, highC, busyC);
            check($sformatf("rand%0d busy cycles", i), busyC, 154);
        end

        // frameIn change and start pulse mid-frame must not disturb the frame in flight.
        runSmall("midframe", 24'h5A3C96, 1'b1, highC, busyC);
        check("midframe busy cycles", busyC, 154);

        // start asserted on the done cycle alone is dropped.
        busS.frameIn = 24'hC0FFEE;
        busS.start   = 1'b1;
        @(negedge clk);
        busS.start = 1'b0;
        for (int c = 0; c < 200 && !busS.done; c++) @(negedge clk);
        check("done reached A", busS.done, 1);
        busS.start = 1'b1;
        @(negedge clk);
        check("start on done ignored", busS.busy, 0);
        busS.start = 1'b0;
        @(negedge clk);
        check("still idle after done", busS.busy, 0);

        // start held through the done cycle is taken once IDLE is reached.
        busS.start = 1'b1;
        @(negedge clk);
        busS.start = 1'b0;
        for (int c = 0; c < 200 && !busS.done; c++) @(negedge clk);
        check("done reached B", busS.done, 1);
        busS.start = 1'b1;
        @(negedge clk);
        check("idle after done B", busS.busy, 0);
        @(negedge clk);
        busS.start = 1'b0;
        check("start resampled busy", busS.busy, 1);
        check("start resampled dout", busS.dout, 1);
        for (int c = 0; c < 200 && busS.busy; c++) @(negedge clk);
        check("idle after resampled frame", busS.busy, 0);

        // Reset during bit 10.
        busS.frameIn = 24'hFFFFFF;
        busS.start   = 1'b1;
        @(negedge clk);
        busS.start = 1'b0;
        repeat (10 * S_TBIT) @(negedge clk);
        check("bit10 dout before reset", busS.dout, 1);
        #2 reset = 1'b1;
        #1;
        check("async reset dout", busS.dout, 0);
        check("async reset busy", busS.busy, 1);
        @(negedge clk);
        reset = 1'b0;
        watchLatch("reset latch");
        rf = 24'($urandom);
        runSmall("after reset", rf, 1'b0, highC, busyC);
        check("after reset busy cycles", busyC, 154);

        // Default timing, start held high: two back-to-back frames decoded from pulse widths.
        for (int c = 0; c < 7000 && busD.busy; c++) @(negedge clk);
        check("default idle", busD.busy, 0);
        fD = 96'h00F000_0000F0_00F000_0000F0;
        busD.frameIn = fD;
        busD.start   = 1'b1;
        t = 0; hiLen = 0; prevD = 1'b0;
        for (int c = 0; c < 40000 && lens.size() < 192; c++) begin
            @(negedge clk);
            if (busD.dout && !prevD) rises.push_back(t);
            if (busD.dout) hiLen++;
            if (!busD.dout && prevD) begin
                lens.push_back(hiLen);
                hiLen = 0;
            end
            prevD = busD.dout;
            t++;
        end
        busD.start = 1'b0;
        check("default pulses", lens.size(), 192);
        bad = 0;
        foreach (lens[i]) if (lens[i] != 40 && lens[i] != 80) bad++;
        check("default bad widths", bad, 0);
        for (int f = 0; f < 2; f++) begin
            dec = '0;
            for (int i = 0; i < 96; i++)
                if (f * 96 + i < lens.size()) dec[95 - i] = (lens[f * 96 + i] == 80);
            check($sformatf("default decoded frame%0d", f), dec, fD);
        end
        if (rises.size() >= 97) check("default frame period", rises[96] - rises[0], 96 * 125 + 6000 + 1);
        else check("default rising edges", rises.size(), 97);
        for (int c = 0; c < 7000 && busD.busy; c++) @(negedge clk);
        check("default idle at end", busD.busy, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
